imm_pack: RTL
=============

// Module: imm_pack
// PURPOSE
// - Inverse of the immediate extender: packs a 32-bit immediate into the immediate bit positions of an RV32IM instruction word.
// - Selected by the same 3-bit IMM_SEL codes; flags immediates that the selected format cannot represent.
// - 2-stage valid/ready pipeline. Used by the self-test/debug instruction injector to build instructions before they enter the fetch path.
// PARAMETERS
// - ERR_CNT_W  8  width of the saturating error counter
// PORTS
// - CLK        in   1   clock, all state on rising edge
// - RST_N      in   1   asynchronous, active-low reset
// - IN_VALID   in   1   request valid
// - IN_READY   out  1   request accepted when IN_VALID & IN_READY
// - IMM_SEL    in   3   format: U=000 J=001 B=010 S=011 I=100 I_SHFT=101 IU=111; 110 is illegal
// - IMM        in   32  immediate value (byte offset for J/B)
// - BASE       in   32  instruction template; bits outside the immediate field pass through
// - OUT_VALID  out  1   result valid
// - OUT_READY  in   1   result consumed when OUT_VALID & OUT_READY
// - OUT_INSTR  out  32  packed instruction
// - OUT_ERR    out  1   immediate not representable, or illegal IMM_SEL
// - ERR_CNT    out  ERR_CNT_W  count of OUT_ERR results handed off; saturates
// BEHAVIOUR
// - Reset: OUT_VALID=0, OUT_INSTR=0, OUT_ERR=0, ERR_CNT=0, both stage valids 0. IN_READY=1 after reset.
// - Stage S1 registers BASE, IMM and IMM_SEL, plus the range-check result.
//   - s1_adv = !s2_v | OUT_READY
//   - IN_READY = !s1_v | s1_adv (combinational, no bubble at full throughput)
// - Stage S2 registers the merged word. OUT_INSTR and OUT_ERR are S2 registers.
// - Latency: result is valid 2 cycles after acceptance. Throughput: 1 per cycle.
// - While OUT_VALID=1 and OUT_READY=0, OUT_INSTR and OUT_ERR hold stable. No drops, no duplicates, order preserved.
// - Field placement (ISA bit positions), all other bits taken from BASE:
//   - U:      [31:12] = IMM[31:12]
//   - J:      [31] = IMM[20]; [30:21] = IMM[10:1]; [20] = IMM[11]; [19:12] = IMM[19:12]
//   - B:      [31] = IMM[12]; [30:25] = IMM[10:5]; [11:8] = IMM[4:1]; [7] = IMM[11]
//   - S:      [31:25] = IMM[11:5]; [11:7] = IMM[4:0]
//   - I, IU:  [31:20] = IMM[11:0]
//   - I_SHFT: [24:20] = IMM[4:0]; BASE[31:25] is kept (funct7, e.g. SRAI)
//   - 110:    OUT_INSTR = BASE
// - Error conditions (bits are still packed, truncated, whenever ERR=1):
//   - U:      IMM[11:0] != 0
//   - J:      IMM[0] != 0, or IMM[31:21] is not all equal to IMM[20]
//   - B:      IMM[0] != 0, or IMM[31:13] is not all equal to IMM[12]
//   - S, I:   IMM[31:12] is not all equal to IMM[11]
//   - I_SHFT: IMM[31:5] != 0
//   - IU:     IMM[31:12] != 0
//   - 110:    always
// - ERR_CNT increments by 1 on each output handshake with OUT_ERR=1. It holds at 2^ERR_CNT_W-1.
// - Reset asserted mid-operation: both stages are flushed immediately and ERR_CNT clears. In-flight requests are lost by design.
// STRUCTURE
// - Shared package: IMM_SEL localparams (IMM_U..IMM_IU), the same codes the control unit and extender use.
// - One sub-module is natural: imm_pack_fmt. It is purely combinational ({IMM_SEL, IMM, BASE} -> {instr, err}) and is instanced between S1 and S2.
// - Handshake logic and the counter stay in the top module.
// TESTING
// - I: BASE=0x00000013, IMM=0xFFFFFFFF -> OUT_INSTR=0xFFF00013, ERR=0, OUT_VALID 2 cycles after accept.
// - B: BASE=0x00000063, IMM=0xFFFFFFFE -> 0xFE000FE3, ERR=0.
// - J: BASE=0x0000006F, IMM=0x800 -> 0x0010006F, ERR=0.
// - J: IMM=0x3 -> ERR=1, ERR_CNT 0->1 on handshake.
// - I_SHFT: BASE=0x40005013, IMM=7 -> 0x40705013.
// - I_SHFT: IMM=32 -> ERR=1.
// - Backpressure: hold OUT_READY=0 for 5 cycles while offering 3 requests.
//   - IN_READY=0 after 2 accepts.
//   - On release, 3 results emerge in order and OUT_INSTR is stable while stalled.
// - Saturation and reset: ERR_CNT_W=2 with 5 errors -> ERR_CNT=3.
// - Reset with both stages full -> OUT_VALID=0 and ERR_CNT=0 immediately.
// - Random: compare 10k random {IMM_SEL, IMM, BASE} against a golden model; for legal U/B/S/I/I_SHFT/IU cases, the imm_ext decode of OUT_INSTR[31:7] equals IMM.

Source files
------------

// File: rtl/imm_pack_pkg.sv
// Shared immediate-format select codes and the pipeline payload types for imm_pack.
// Latency: n/a (package). Backpressure: n/a.
// Holds the IMM_SEL codes used by the control unit, extender and packer, plus the range-check helper.
package imm_pack_pkg;

    // Immediate format select codes (same encoding as the immediate extender).
    localparam logic [2:0] IMM_U      = 3'b000;
    localparam logic [2:0] IMM_J      = 3'b001;
    localparam logic [2:0] IMM_B      = 3'b010;
    localparam logic [2:0] IMM_S      = 3'b011;
    localparam logic [2:0] IMM_I      = 3'b100;
    localparam logic [2:0] IMM_I_SHFT = 3'b101;
    localparam logic [2:0] IMM_BAD    = 3'b110;
    localparam logic [2:0] IMM_IU     = 3'b111;

    // S1 payload: request operands plus the registered range-check result.
    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
        logic        rng_err;
    } s1_t;

    // S2 payload: the merged instruction word and its error flag.
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } s2_t;

    // Range check for the legal formats: 1 when the selected format cannot
    // hold the immediate exactly. The illegal select code returns 0 here; it
    // is flagged separately by the formatter so the two causes stay distinct.
    function automatic logic imm_range_err(input logic [2:0] sel, input logic [31:0] imm);
        logic e;
        e = 1'b0;
        case (sel)
            IMM_U:      e = (imm[11:0] != 12'd0);
            IMM_J:      e = imm[0] || (imm[31:21] != {11{imm[20]}});
            IMM_B:      e = imm[0] || (imm[31:13] != {19{imm[12]}});
            IMM_S,
            IMM_I:      e = (imm[31:12] != {20{imm[11]}});
            IMM_I_SHFT: e = (imm[31:5] != 27'd0);
            IMM_IU:     e = (imm[31:12] != 20'd0);
            default:    e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Request/result bundle for the immediate packer.
// Latency: n/a (interface). Backpressure: IN_VALID/IN_READY on requests, OUT_VALID/OUT_READY on results.
// master = instruction injector side, slave = imm_pack side.
interface imm_pack_if;
    import imm_pack_pkg::*;

    // Request channel
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  IMM_SEL;
    logic [31:0] IMM;
    logic [31:0] BASE;

    // Result channel
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_INSTR;
    logic        OUT_ERR;

    modport master (
        output IN_VALID, IMM_SEL, IMM, BASE, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_INSTR, OUT_ERR
    );

    modport slave (
        input  IN_VALID, IMM_SEL, IMM, BASE, OUT_READY,
        output IN_READY, OUT_VALID, OUT_INSTR, OUT_ERR
    );

endinterface

// File: rtl/imm_pack_fmt.sv
// Places an immediate into the instruction-word bit positions of the selected RV32 format.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: sel/imm/base in; instr = base with the immediate field overwritten; err = illegal select code.
module imm_pack_fmt
    import imm_pack_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic        err
);

    // Bits outside the immediate field always come from the template. Out of
    // range immediates are still packed, simply truncated to the field width.
    always_comb begin
        instr = base;
        err   = 1'b0;
        case (sel)
            IMM_U: begin
                instr[31:12] = imm[31:12];
            end
            IMM_J: begin
                // imm[20|10:1|11|19:12]
                instr[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]};
            end
            IMM_B: begin
                // imm[12|10:5] ... imm[4:1|11]
                instr[31:25] = {imm[12], imm[10:5]};
                instr[11:7]  = {imm[4:1], imm[11]};
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
            end
            IMM_I,
            IMM_IU: begin
                instr[31:20] = imm[11:0];
            end
            IMM_I_SHFT: begin
                // Only the shamt field; base[31:25] keeps funct7 (e.g. SRAI).
                instr[24:20] = imm[4:0];
            end
            default: begin
                // Code 110 has no format: template passes through untouched.
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// Packs a 32-bit immediate into an RV32IM instruction template, flagging unrepresentable immediates.
// Latency: 2 cycles from request accept to OUT_VALID; 1 result per cycle sustained.
// Backpressure: OUT_READY=0 freezes S2 (outputs stable); IN_READY drops only when both stages are full and stalled.
// Ports: CLK, RST_N (async active-low); bus = imm_pack_if slave (request + result channels);
//        ERR_CNT = saturating count of results handed off with OUT_ERR=1.
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    imm_pack_if.slave            bus,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    // Pipeline state
    logic                 s1_v_q, s1_v_d;
    s1_t                  s1_q,   s1_d;
    logic                 s2_v_q, s2_v_d;
    s2_t                  s2_q,   s2_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Handshake terms
    logic s1_adv;
    logic in_ready;
    logic out_hs;

    // Formatter output for the operands currently held in S1
    logic [31:0] fmt_instr;
    logic        fmt_err;

    // S1 may move forward whenever S2 is empty or being drained this cycle.
    assign s1_adv   = !s2_v_q || bus.OUT_READY;
    // S1 accepts when empty or when its content is leaving; no bubble at full rate.
    assign in_ready = !s1_v_q || s1_adv;
    assign out_hs   = s2_v_q && bus.OUT_READY;

    imm_pack_fmt u_fmt (
        .sel   (s1_q.sel),
        .imm   (s1_q.imm),
        .base  (s1_q.base),
        .instr (fmt_instr),
        .err   (fmt_err)
    );

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_d      = s1_q;
        s2_v_d    = s2_v_q;
        s2_d      = s2_q;
        err_cnt_d = err_cnt_q;

        // Stage 1: capture the request and its range check.
        if (in_ready) begin
            s1_v_d = bus.IN_VALID;
            if (bus.IN_VALID) begin
                s1_d = '{sel:     bus.IMM_SEL,
                         imm:     bus.IMM,
                         base:    bus.BASE,
                         rng_err: imm_range_err(bus.IMM_SEL, bus.IMM)};
            end
        end

        // Stage 2: register the merged word. When S1 is empty the data fields
        // hold their last value; only the valid bit drops.
        if (s1_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_d = '{instr: fmt_instr,
                         err:   s1_q.rng_err || fmt_err};
            end
        end

        // Count erroneous results at hand-off; stick at all-ones.
        if (out_hs && s2_q.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_v_q    <= 1'b0;
            s1_q      <= '0;
            s2_v_q    <= 1'b0;
            s2_q      <= '0;
            err_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_q      <= s1_d;
            s2_v_q    <= s2_v_d;
            s2_q      <= s2_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = s2_v_q;
    assign bus.OUT_INSTR = s2_q.instr;
    assign bus.OUT_ERR   = s2_q.err;
    assign ERR_CNT       = err_cnt_q;

endmodule
